// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state encoding and
// an index-width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // $clog2 floored at 1 so a single-chunk design still gets a 1-bit index
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Request/result bundle of the chunked adder/subtractor; master drives the
// operands and start, slave returns the handshake and result flags.
interface chunked_addsub_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/chunked_addsub_fa_chunk.sv
// Combinational CHUNK-bit ripple of full adders. Also exposes the carry into
// the top bit so the caller can derive signed overflow.
module fa_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c[0] = ci_i;
    for (int k = 0; k < CHUNK; k++) begin
      s_o[k]   = a_i[k] ^ b_i[k] ^ c[k];
      c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
    end
  end

  assign co_o       = c[CHUNK];
  assign c_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through one full-adder
// slice and a carry flop, with start/busy/done handshake and carry/overflow flags.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic           clk,
  input  logic           rst,
  chunked_addsub_if.slave bus
);

  localparam int NCYC = WIDTH / CHUNK;
  localparam int IW   = clog2_min1(NCYC);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, w_q, w_d, sum_q;
  logic             c_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             co, c_msb;
  logic             last, load;

  assign last = (idx_q == IW'(NCYC - 1));
  assign load = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand slice steering: one adder slice serves every chunk position
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < NCYC; i++) begin
      if (idx_q == IW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  fa_chunk #(.CHUNK(CHUNK)) u_fa (
    .a_i        (a_ch),
    .b_i        (b_ch),
    .ci_i       (c_q),
    .s_o        (s_ch),
    .co_o       (co),
    .c_msb_in_o (c_msb)
  );

  always_comb begin
    w_d = w_q;
    for (int i = 0; i < NCYC; i++) begin
      if (idx_q == IW'(i)) w_d[i*CHUNK +: CHUNK] = s_ch;
    end
  end

  // Subtraction is folded in at load time as a + ~b + ~cin
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      w_q    <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      a_q   <= bus.a;
      b_q   <= bus.b ^ {WIDTH{bus.sub}};
      c_q   <= bus.cin ^ bus.sub;
      idx_q <= '0;
    end else if (state_q == S_RUN) begin
      w_q   <= w_d;
      c_q   <= co;
      idx_q <= last ? '0 : idx_q + IW'(1);
      if (last) begin
        sum_q  <= w_d;
        cout_q <= co;
        ovf_q  <= co ^ c_msb;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three instances (CHUNK 1/4/8, WIDTH 8) compared
// against an arithmetic model of a +/- b +/- cin.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(8)) if1 ();
  chunked_addsub_if #(.WIDTH(8)) if4 ();
  chunked_addsub_if #(.WIDTH(8)) if8 ();

  chunked_addsub #(.WIDTH(8), .CHUNK(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  chunked_addsub #(.WIDTH(8), .CHUNK(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  chunked_addsub #(.WIDTH(8), .CHUNK(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit st, input logic [7:0] a, input logic [7:0] b,
                       input bit cin, input bit sub);
    case (sel)
      1: begin if1.start = st; if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub; end
      4: begin if4.start = st; if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub; end
      default: begin if8.start = st; if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; end
    endcase
  endtask

  task automatic drive_rand(input int sel, input bit st);
    drive(sel, st, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // {busy, done, ovf, cout, sum}
  function automatic logic [11:0] rd(input int sel);
    case (sel)
      1:       return {if1.busy, if1.done, if1.ovf, if1.cout, if1.sum};
      4:       return {if4.busy, if4.done, if4.ovf, if4.cout, if4.sum};
      default: return {if8.busy, if8.done, if8.ovf, if8.cout, if8.sum};
    endcase
  endfunction

  // Reference: true signed/unsigned arithmetic, returns {ovf, cout, sum}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input bit cin, input bit sub);
    int sa, sb, ua, ub, r, u;
    bit c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    if (!sub) begin
      r = sa + sb + int'(cin);
      u = ua + ub + int'(cin);
      c = (u > 255);
    end else begin
      r = sa - sb - int'(cin);
      u = ua - ub - int'(cin);
      c = (ua >= ub + int'(cin));
    end
    v = (r > 127) || (r < -128);
    return {v, c, u[7:0]};
  endfunction

  task automatic check_res(input int sel, input string tag, input logic [7:0] a,
                           input logic [7:0] b, input bit cin, input bit sub);
    logic [11:0] r;
    logic [9:0]  m;
    r = rd(sel);
    m = model(a, b, cin, sub);
    check({tag, ".sum"},  32'(r[7:0]), 32'(m[7:0]));
    check({tag, ".cout"}, 32'(r[8]),   32'(m[8]));
    check({tag, ".ovf"},  32'(r[9]),   32'(m[9]));
    check({tag, ".busy_in_done"}, 32'(r[11]), 32'd0);
  endtask

  // Called #1 after the accepting edge; counts that edge as 1.
  // glitch >= 0 pulses start with junk operands while the op is running.
  task automatic wait_done(input int sel, input int glitch, output int edges, output int busyc);
    logic [11:0] r;
    edges = 1;
    busyc = 0;
    r = rd(sel);
    while (!r[10] && edges < 64) begin
      if (r[11]) busyc++;
      if (glitch >= 0) drive_rand(sel, edges == glitch);
      @(posedge clk); #1;
      edges++;
      r = rd(sel);
    end
  endtask

  task automatic run_op(input int sel, input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit cin, input bit sub, input int exp_lat, input int glitch);
    int edges, busyc;
    drive(sel, 1'b1, a, b, cin, sub);
    @(posedge clk); #1;
    drive_rand(sel, 1'b0);
    wait_done(sel, glitch, edges, busyc);
    check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(busyc), 32'(exp_lat - 1));
    check_res(sel, tag, a, b, cin, sub);
  endtask

  initial begin
    int edges, busyc, dones;
    logic [11:0] r;
    logic [7:0] ra, rb;
    bit rc, rs;

    rst = 1'b1;
    drive(1, 0, 8'h00, 8'h00, 0, 0);
    drive(4, 0, 8'h00, 8'h00, 0, 0);
    drive(8, 0, 8'h00, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.u1", 32'(rd(1)), 32'd0);
    check("reset.u4", 32'(rd(4)), 32'd0);
    check("reset.u8", 32'(rd(8)), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic on the bit-serial instance
    run_op(1, "add_7f_01", 8'h7F, 8'h01, 0, 0, 9, -1);
    check("add_7f_01.sum_const", 32'(rd(1) & 12'h0FF), 32'h80);
    @(posedge clk); #1;
    r = rd(1);
    check("add_7f_01.done_one_cycle", 32'(r[10]), 32'd0);
    check("add_7f_01.sum_held", 32'(r[7:0]), 32'h80);
    run_op(1, "add_ff_01",   8'hFF, 8'h01, 0, 0, 9, -1);
    run_op(1, "add_10_20_c", 8'h10, 8'h20, 1, 0, 9, -1);
    run_op(1, "sub_05_07",   8'h05, 8'h07, 0, 1, 9, -1);
    run_op(1, "sub_80_01",   8'h80, 8'h01, 0, 1, 9, -1);
    run_op(1, "sub_03_01_c", 8'h03, 8'h01, 1, 1, 9, -1);

    // start pulsed mid-RUN must be ignored
    run_op(1, "start_in_run", 8'h3C, 8'h5A, 0, 0, 9, 3);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      r = rd(1);
      if (r[10]) dones++;
    end
    check("start_in_run.extra_done", 32'(dones), 32'd0);

    // Back-to-back: start held from RUN through DONE
    drive(1, 1, 8'h12, 8'h34, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 8'hA5, 8'h0F, 1, 1);
    wait_done(1, -1, edges, busyc);
    check("b2b_first.latency", 32'(edges), 32'd9);
    check_res(1, "b2b_first", 8'h12, 8'h34, 0, 0);
    @(posedge clk); #1;
    drive_rand(1, 1'b0);
    r = rd(1);
    check("b2b_second.busy", 32'(r[11]), 32'd1);
    wait_done(1, -1, edges, busyc);
    check("b2b_second.latency", 32'(edges), 32'd9);
    check_res(1, "b2b_second", 8'hA5, 8'h0F, 1, 1);
    @(posedge clk); #1;

    // Reset during RUN aborts and clears the held result
    drive(1, 1, 8'h55, 8'h22, 0, 0);
    @(posedge clk); #1;
    drive_rand(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_run.outputs", 32'(rd(1)), 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      r = rd(1);
      if (r[10] || r[11]) dones++;
    end
    check("rst_mid_run.stays_idle", 32'(dones), 32'd0);
    run_op(1, "after_rst", 8'hC8, 8'h64, 0, 1, 9, -1);

    // Randomised operations on all three chunk sizes
    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(4, "rand_c4", ra, rb, rc, rs, 3, -1);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(8, "rand_c8", ra, rb, rc, rs, 2, -1);
    end
    for (int n = 0; n < 8; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(1, "rand_c1", ra, rb, rc, rs, 9, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
